mio_bus: RTL and testbench
==========================

// Module: mio_bus
// PURPOSE
//  Memory/IO bus controller between the multicycle CPU datapath and its slaves.
//  Takes the CPU word access (M_addr, store data, mem_r/mem_w); decodes RAM/ROM/IO regions.
//  Sequences wait states and IO handshakes, then returns data2CPU with a one-cycle MIO_ready.
//  Sits directly downstream of the datapath's memory address/data ports.
// PARAMETERS
//  RAM_AW      12   RAM word-address width (ram_addr = M_addr[RAM_AW+1:2])
//  RAM_WAIT    2    RAM access cycles; values <2 are treated as 2
//  ROM_WAIT    2    ROM access cycles; values <2 are treated as 2
//  IO_TIMEOUT  255  max cycles io_req waits for io_ack before bus error (8-bit counter)
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rst        in   1       asynchronous, active-low reset (rst==0 resets)
//  mem_r      in   1       CPU read request, held until MIO_ready seen
//  mem_w      in   1       CPU write request, held until MIO_ready seen
//  M_addr     in   32      CPU byte address, [1:0] ignored (word access)
//  data_out   in   32      CPU store data
//  data2CPU   out  32      read data to CPU (IR/MDR source)
//  MIO_ready  out  1       access complete, one-cycle pulse
//  bus_err    out  1       access faulted; only valid with MIO_ready
//  ram_en     out  1       RAM strobe;  ram_we out 1 write enable
//  ram_addr   out  RAM_AW  RAM word address
//  ram_wdata  out  32      RAM write data;  ram_rdata in 32, valid cycle after ram_en, held
//  rom_en     out  1       ROM strobe;  rom_addr out 12;  rom_rdata in 32 (same timing as RAM)
//  io_req     out  1       IO request, held until io_ack or timeout
//  io_we      out  1       IO write;  io_addr out 16 (M_addr[15:0]);  io_wdata out 32
//  io_rdata   in   32      IO read data, sampled with io_ack;  io_ack in 1 slave done
// BEHAVIOUR
//  Decode on M_addr[31:28]: 0x0 RAM, 0x3 ROM, 0xE/0xF IO, all others unmapped.
//  FSM states IDLE, ACCESS, IOWAIT, DONE. Reset -> IDLE. All outputs 0, data2CPU=0.
//  IDLE:
//   - (mem_r|mem_w) sampled -> latch addr, data, region and write flag (mem_w wins if both).
//   - RAM/ROM -> ACCESS (counter=WAIT-1); IO -> IOWAIT (timer=0).
//   - Unmapped, or write to ROM -> DONE with bus_err, no strobe issued.
//  ACCESS:
//   - ram_en/rom_en (and ram_we for writes) high only in the first ACCESS cycle.
//   - Counter decrements each cycle; on the edge where it is 0 -> DONE.
//   - Reads latch ram_rdata/rom_rdata into data2CPU on that edge.
//  Latency: request first high in cycle 0 -> MIO_ready high in cycle WAIT+1 (3 for default).
//  IOWAIT:
//   - io_req, io_we, io_addr, io_wdata registered and stable throughout.
//   - io_ack sampled -> latch io_rdata (reads), go to DONE, drop io_req next cycle.
//   - Timer reaches IO_TIMEOUT without ack -> DONE, bus_err=1, data2CPU=32'hFFFF_FFFF.
//  DONE: MIO_ready=1 (bus_err as flagged) for exactly one cycle -> IDLE.
//   - Request inputs are ignored in DONE; the next request is accepted from IDLE.
//  data2CPU changes only on read completion; writes and errors other than IO timeout leave it unchanged.
//  io_ack outside IOWAIT is ignored. Changes to M_addr/data_out after capture have no effect.
//  rst low mid-access: strobes, io_req and MIO_ready drop asynchronously.
//   - FSM -> IDLE; a RAM write whose ram_en cycle already occurred stays committed.
// TESTING
//  1 RAM write M_addr=0x0000_0010 data 0x1234_5678, then read:
//    ram_we for one cycle at ram_addr=4; read MIO_ready in cycle 3, data2CPU=0x1234_5678.
//  2 ROM read at 0x3000_0000 (reset PC) with rom_rdata=0x2408_0001:
//    rom_addr=0, MIO_ready cycle 3, bus_err=0. ROM write -> MIO_ready cycle 1, bus_err=1.
//  3 IO read 0xE000_0004, slave acks after 5 cycles with 0xA5A5_0000:
//    io_req high 5 cycles, io_addr=0x0004, data2CPU=0xA5A5_0000, one MIO_ready pulse.
//  4 IO access, io_ack never asserted:
//    MIO_ready with bus_err=1 after IO_TIMEOUT cycles, data2CPU=0xFFFF_FFFF; stray io_ack later ignored.
//  5 Read from 0x5000_0000 -> DONE next cycle, bus_err=1, no strobes, data2CPU unchanged.
//  6 Boundaries:
//    - rst low during IOWAIT -> io_req=0 immediately; after release, a fresh RAM read completes normally.
//    - Back-to-back requests held across DONE -> exactly one MIO_ready per access.

Source files
------------

// File: rtl/mio_bus_if.sv
// mio_bus_if: CPU word-access handshake between the datapath and the memory/IO bus controller.
interface mio_bus_if;
    logic        mem_r;
    logic        mem_w;
    logic [31:0] M_addr;
    logic [31:0] data_out;
    logic [31:0] data2CPU;
    logic        MIO_ready;
    logic        bus_err;
    modport master (output mem_r, mem_w, M_addr, data_out, input data2CPU, MIO_ready, bus_err);
    modport slave  (input mem_r, mem_w, M_addr, data_out, output data2CPU, MIO_ready, bus_err);
endinterface

// File: rtl/mio_bus.sv
// mio_bus: decodes CPU word accesses to RAM/ROM/IO, sequences wait states and IO handshakes.
module mio_bus #(
    parameter int RAM_AW     = 12,
    parameter int RAM_WAIT   = 2,
    parameter int ROM_WAIT   = 2,
    parameter int IO_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    mio_bus_if.slave          cpu,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              rom_en,
    output logic [11:0]       rom_addr,
    input  logic [31:0]       rom_rdata,
    output logic              io_req,
    output logic              io_we,
    output logic [15:0]       io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata,
    input  logic              io_ack
);
    localparam int RW = (RAM_WAIT < 2) ? 2 : RAM_WAIT;
    localparam int OW = (ROM_WAIT < 2) ? 2 : ROM_WAIT;
    localparam logic [7:0] RAM_CNT = 8'(RW - 1);
    localparam logic [7:0] ROM_CNT = 8'(OW - 1);
    localparam logic [7:0] TO_LAST = 8'(IO_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, IOWAIT, DONE} state_t;
    typedef enum logic [1:0] {R_RAM, R_ROM, R_IO, R_NONE} region_t;

    state_t      state, nxt;
    region_t     dec, reg_q;
    logic [31:0] addr_q, wdata_q;
    logic        we_q, first, err_q, req, bad;
    logic [7:0]  cnt, timer;

    assign req = cpu.mem_r | cpu.mem_w;
    assign dec = (cpu.M_addr[31:28] == 4'h0)      ? R_RAM :
                 (cpu.M_addr[31:28] == 4'h3)      ? R_ROM :
                 (cpu.M_addr[31:29] == 3'b111)    ? R_IO  : R_NONE;
    // Unmapped regions and ROM writes fault without ever strobing a slave.
    assign bad = (dec == R_NONE) || (dec == R_ROM && cpu.mem_w);

    assign ram_en        = (state == ACCESS) && first && (reg_q == R_RAM);
    assign ram_we        = ram_en && we_q;
    assign ram_addr      = addr_q[RAM_AW+1:2];
    assign ram_wdata     = wdata_q;
    assign rom_en        = (state == ACCESS) && first && (reg_q == R_ROM);
    assign rom_addr      = addr_q[13:2];
    assign io_req        = (state == IOWAIT);
    assign io_we         = io_req && we_q;
    assign io_addr       = addr_q[15:0];
    assign io_wdata      = wdata_q;
    assign cpu.MIO_ready = (state == DONE);
    assign cpu.bus_err   = (state == DONE) && err_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !req ? IDLE : bad ? DONE : (dec == R_IO) ? IOWAIT : ACCESS;
            ACCESS:  nxt = (cnt == 8'd0) ? DONE : ACCESS;
            IOWAIT:  nxt = (io_ack || timer == TO_LAST) ? DONE : IOWAIT;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            reg_q        <= R_NONE;
            first        <= 1'b0;
            err_q        <= 1'b0;
            cnt          <= '0;
            timer        <= '0;
            cpu.data2CPU <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    addr_q  <= cpu.M_addr;
                    wdata_q <= cpu.data_out;
                    we_q    <= cpu.mem_w;
                    reg_q   <= dec;
                    first   <= 1'b1;
                    err_q   <= bad;
                    cnt     <= (dec == R_ROM) ? ROM_CNT : RAM_CNT;
                    timer   <= '0;
                end
                ACCESS: begin
                    first <= 1'b0;
                    cnt   <= cnt - 8'd1;
                    if (cnt == 8'd0 && !we_q)
                        cpu.data2CPU <= (reg_q == R_RAM) ? ram_rdata : rom_rdata;
                end
                IOWAIT: begin
                    timer <= timer + 8'd1;
                    if (io_ack) begin
                        if (!we_q) cpu.data2CPU <= io_rdata;
                    end else if (timer == TO_LAST) begin
                        err_q        <= 1'b1;
                        cpu.data2CPU <= 32'hFFFF_FFFF;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mio_bus.sv
// tb_mio_bus: directed bench with a result scoreboard and RAM/ROM slave models for mio_bus.
module tb_mio_bus;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ram_en, ram_we, rom_en, io_req, io_we, io_ack;
    logic [11:0] ram_addr, rom_addr;
    logic [15:0] io_addr;
    logic [31:0] ram_wdata, ram_rdata, rom_rdata, io_wdata, io_rdata;
    logic [31:0] ram_mem [4096];

    typedef struct packed {logic e; logic [31:0] d;} exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0;
    int lat, n_ram, n_we, n_rom, n_io, n_rdy, n_other;
    logic [31:0] last_ram_addr, last_rom_addr, last_io_addr;

    mio_bus_if b();

    mio_bus dut (
        .clk(clk), .rst(rst), .cpu(b.slave),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            ram_rdata <= ram_mem[ram_addr];
        end
        if (rom_en) rom_rdata <= (rom_addr == 12'd0) ? 32'h2408_0001 : {20'h0, rom_addr};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_data"}, b.data2CPU, e.d);
        chk({tag, "_err"}, {31'd0, b.bus_err}, {31'd0, e.e});
    endtask

    // Drives one access and waits for MIO_ready; ack_after=0 means the IO slave never answers.
    task automatic access(input string tag, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_d, input bit exp_e, input int exp_lat,
                          input int ack_after, input logic [31:0] io_d);
        sb.push_back('{e: exp_e, d: exp_d});
        n_ram = 0; n_we = 0; n_rom = 0; n_io = 0; lat = 0;
        @(negedge clk);
        b.mem_w = wr; b.mem_r = !wr; b.M_addr = a; b.data_out = d;
        while (lat < 400) begin
            @(negedge clk);
            lat++;
            io_ack = 1'b0;
            if (lat == 1) begin b.M_addr = ~a; b.data_out = ~d; end
            if (ram_en) begin n_ram++; last_ram_addr = {20'd0, ram_addr}; end
            if (ram_we) n_we++;
            if (rom_en) begin n_rom++; last_rom_addr = {20'd0, rom_addr}; end
            if (io_req) begin n_io++; last_io_addr = {16'd0, io_addr}; end
            if (b.MIO_ready) break;
            if (io_req && n_io == ack_after) begin io_ack = 1'b1; io_rdata = io_d; end
        end
        b.mem_r = 1'b0; b.mem_w = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        pop_chk(tag);
    endtask

    initial begin
        b.mem_r = 0; b.mem_w = 0; b.M_addr = 0; b.data_out = 0;
        io_ack = 0; io_rdata = 0; ram_rdata = 0; rom_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, b.MIO_ready}, 32'd0);
        chk("rst_data", b.data2CPU, 32'd0);
        chk("rst_strobes", {29'd0, ram_en, rom_en, io_req}, 32'd0);
        rst = 1'b1;

        access("ram_wr", 1, 32'h0000_0010, 32'h1234_5678, 32'd0, 0, 3, 0, 0);
        chk("ram_wr_we", 32'(n_we), 32'd1);
        chk("ram_wr_addr", last_ram_addr, 32'd4);
        access("ram_rd", 0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 3, 0, 0);
        chk("ram_rd_en", 32'(n_ram), 32'd1);
        chk("ram_rd_we", 32'(n_we), 32'd0);

        access("rom_rd", 0, 32'h3000_0000, 32'h0, 32'h2408_0001, 0, 3, 0, 0);
        chk("rom_rd_addr", last_rom_addr, 32'd0);
        access("rom_wr", 1, 32'h3000_0000, 32'h5555_5555, 32'h2408_0001, 1, 1, 0, 0);
        chk("rom_wr_nostrobe", 32'(n_rom + n_ram), 32'd0);

        access("io_rd", 0, 32'hE000_0004, 32'h0, 32'hA5A5_0000, 0, 6, 5, 32'hA5A5_0000);
        chk("io_rd_req", 32'(n_io), 32'd5);
        chk("io_rd_addr", last_io_addr, 32'h0000_0004);

        access("io_to", 0, 32'hF000_0100, 32'h0, 32'hFFFF_FFFF, 1, 256, 0, 0);
        chk("io_to_req", 32'(n_io), 32'd255);
        n_rdy = 0; n_other = 0;
        io_ack = 1'b1; io_rdata = 32'h1111_1111;
        repeat (3) begin
            @(negedge clk);
            if (b.MIO_ready) n_rdy++;
            if (io_req) n_other++;
        end
        io_ack = 1'b0;
        chk("stray_ack_ready", 32'(n_rdy), 32'd0);
        chk("stray_ack_req", 32'(n_other), 32'd0);
        chk("stray_ack_data", b.data2CPU, 32'hFFFF_FFFF);

        access("unmapped", 0, 32'h5000_0000, 32'h0, 32'hFFFF_FFFF, 1, 1, 0, 0);
        chk("unmapped_nostrobe", 32'(n_ram + n_rom + n_io), 32'd0);

        @(negedge clk);
        b.mem_r = 1'b1; b.M_addr = 32'hE000_0008;
        repeat (3) @(negedge clk);
        chk("iowait_req", {31'd0, io_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_async_req", {31'd0, io_req}, 32'd0);
        chk("rst_async_ready", {31'd0, b.MIO_ready}, 32'd0);
        b.mem_r = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        access("post_rst_rd", 0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 3, 0, 0);

        // Request held through three accesses: DONE at cycles 3, 7 and 11.
        repeat (3) sb.push_back('{e: 1'b0, d: 32'h1234_5678});
        @(negedge clk);
        b.mem_r = 1'b1; b.M_addr = 32'h0000_0010;
        n_rdy = 0; n_other = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (b.MIO_ready) begin
                n_rdy++;
                if (i % 4 != 3) n_other++;
                pop_chk("b2b");
            end
        end
        b.mem_r = 1'b0;
        chk("b2b_count", 32'(n_rdy), 32'd3);
        chk("b2b_timing", 32'(n_other), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
